// File: rtl/tmds_pkg.sv
// Constants shared by the TMDS encoder and receiver: control tokens, their CD codes
// and the receiver alignment FSM encoding.
package tmds_pkg;

    localparam int unsigned SYM_W   = 10;
    localparam int unsigned VD_W    = 8;
    localparam int unsigned CD_W    = 2;
    localparam int unsigned PHASE_W = 4;
    localparam int unsigned CNT_W   = 4;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(SYM_W - 1);

    localparam logic [SYM_W-1:0] TOK_CD00 = 10'b1101010100;
    localparam logic [SYM_W-1:0] TOK_CD01 = 10'b0010101011;
    localparam logic [SYM_W-1:0] TOK_CD10 = 10'b0101010100;
    localparam logic [SYM_W-1:0] TOK_CD11 = 10'b1010101011;

    localparam logic [CD_W-1:0] CD_00 = 2'b00;
    localparam logic [CD_W-1:0] CD_01 = 2'b01;
    localparam logic [CD_W-1:0] CD_10 = 2'b10;
    localparam logic [CD_W-1:0] CD_11 = 2'b11;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } rx_state_e;

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one aligned 10-bit TMDS symbol into video data,
// control code and a control-token flag.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [SYM_W-1:0] i_symbol,
    output logic [VD_W-1:0]  o_vd,
    output logic [CD_W-1:0]  o_cd,
    output logic             o_is_token
);

    logic [VD_W-1:0] w_x;

    assign w_x = i_symbol[9] ? ~i_symbol[VD_W-1:0] : i_symbol[VD_W-1:0];

    // Undo the transition-minimising chain; bit 8 selects XOR versus XNOR.
    always_comb begin
        o_vd    = '0;
        o_vd[0] = w_x[0];
        for (int i = 1; i < int'(VD_W); i++) begin
            o_vd[i] = i_symbol[8] ? (w_x[i] ^ w_x[i-1]) : ~(w_x[i] ^ w_x[i-1]);
        end
    end

    always_comb begin
        o_is_token = 1'b1;
        o_cd       = CD_00;
        case (i_symbol)
            TOK_CD00: o_cd = CD_00;
            TOK_CD01: o_cd = CD_01;
            TOK_CD10: o_cd = CD_10;
            TOK_CD11: o_cd = CD_11;
            default:  o_is_token = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_rx_decoder.sv
// Single-channel TMDS receiver: LSB-first deserializer, token-based symbol alignment
// and registered decode of VD/CD/VDE at the pixel rate.
module tmds_rx_decoder
    import tmds_pkg::*;
#(
    parameter int unsigned lock_tokens = 8,
    parameter int unsigned err_limit   = 4
) (
    input  logic             clk_tmds,
    input  logic             reset,
    input  logic             tmds_in,
    output logic             symbol_strobe,
    output logic [VD_W-1:0]  VD,
    output logic [CD_W-1:0]  CD,
    output logic             VDE,
    output logic             locked,
    output logic [SYM_W-1:0] symbol_raw
);

    localparam logic [CNT_W-1:0] LOCK_N = CNT_W'(lock_tokens);
    localparam logic [CNT_W-1:0] ERR_N  = CNT_W'(err_limit);

    rx_state_e          r_state;
    logic [SYM_W-1:0]   r_sr;
    logic [PHASE_W-1:0] r_phase;
    logic [CNT_W-1:0]   r_tok_cnt;
    logic [CNT_W-1:0]   r_err_cnt;
    logic               r_strobe;
    logic [VD_W-1:0]    r_vd;
    logic [CD_W-1:0]    r_cd;
    logic               r_vde;
    logic               r_locked;
    logic [SYM_W-1:0]   r_raw;

    rx_state_e          w_state_nxt;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic [CNT_W-1:0]   w_tok_nxt;
    logic [CNT_W-1:0]   w_err_nxt;
    logic               w_strobe_nxt;
    logic [VD_W-1:0]    w_vd_nxt;
    logic [CD_W-1:0]    w_cd_nxt;
    logic               w_vde_nxt;
    logic               w_locked_nxt;
    logic [SYM_W-1:0]   w_raw_nxt;

    logic [VD_W-1:0]    w_dec_vd;
    logic [CD_W-1:0]    w_dec_cd;
    logic               w_tok_hit;
    logic               w_boundary;
    logic [CNT_W-1:0]   w_tok_inc;
    logic [CNT_W-1:0]   w_err_inc;

    tmds_symbol_decode u_decode (
        .i_symbol   (r_sr),
        .o_vd       (w_dec_vd),
        .o_cd       (w_dec_cd),
        .o_is_token (w_tok_hit)
    );

    assign w_boundary = (r_phase == PHASE_LAST);
    assign w_tok_inc  = r_tok_cnt + CNT_W'(1);
    assign w_err_inc  = r_err_cnt + CNT_W'(1);

    // Deserializer, alignment counters, FSM state and output registers.
    always_ff @(posedge clk_tmds or posedge reset) begin
        if (reset) begin
            r_state   <= ST_HUNT;
            r_sr      <= '0;
            r_phase   <= '0;
            r_tok_cnt <= '0;
            r_err_cnt <= '0;
            r_strobe  <= 1'b0;
            r_vd      <= '0;
            r_cd      <= '0;
            r_vde     <= 1'b0;
            r_locked  <= 1'b0;
            r_raw     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= {tmds_in, r_sr[SYM_W-1:1]};
            r_phase   <= w_phase_nxt;
            r_tok_cnt <= w_tok_nxt;
            r_err_cnt <= w_err_nxt;
            r_strobe  <= w_strobe_nxt;
            r_vd      <= w_vd_nxt;
            r_cd      <= w_cd_nxt;
            r_vde     <= w_vde_nxt;
            r_locked  <= w_locked_nxt;
            r_raw     <= w_raw_nxt;
        end
    end

    // Next state: HUNT anchors the phase on any token, VERIFY counts aligned tokens,
    // LOCKED decodes at boundaries and watches for off-phase tokens.
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = w_boundary ? '0 : r_phase + PHASE_W'(1);
        w_tok_nxt    = r_tok_cnt;
        w_err_nxt    = r_err_cnt;
        w_strobe_nxt = 1'b0;
        w_vd_nxt     = r_vd;
        w_cd_nxt     = r_cd;
        w_vde_nxt    = r_vde;
        w_raw_nxt    = r_raw;

        case (r_state)
            ST_HUNT: begin
                if (w_tok_hit) begin
                    w_state_nxt = ST_VERIFY;
                    w_phase_nxt = '0;
                    w_tok_nxt   = CNT_W'(1);
                    w_err_nxt   = '0;
                end
            end

            ST_VERIFY: begin
                if (w_boundary) begin
                    if (!w_tok_hit) begin
                        w_state_nxt = ST_HUNT;
                        w_tok_nxt   = '0;
                    end else if (w_tok_inc >= LOCK_N) begin
                        w_state_nxt = ST_LOCKED;
                        w_tok_nxt   = LOCK_N;
                        w_err_nxt   = '0;
                    end else begin
                        w_tok_nxt   = w_tok_inc;
                    end
                end
            end

            ST_LOCKED: begin
                if (w_boundary) begin
                    w_strobe_nxt = 1'b1;
                    w_raw_nxt    = r_sr;
                    if (w_tok_hit) begin
                        w_vde_nxt = 1'b0;
                        w_cd_nxt  = w_dec_cd;
                        w_err_nxt = '0;
                    end else begin
                        w_vde_nxt = 1'b1;
                        w_vd_nxt  = w_dec_vd;
                    end
                end else if (w_tok_hit) begin
                    if (w_err_inc >= ERR_N) begin
                        w_state_nxt = ST_HUNT;
                        w_tok_nxt   = '0;
                        w_err_nxt   = '0;
                    end else begin
                        w_err_nxt   = w_err_inc;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_HUNT;
                w_tok_nxt   = '0;
                w_err_nxt   = '0;
            end
        endcase

        w_locked_nxt = (w_state_nxt == ST_LOCKED);
    end

    assign symbol_strobe = r_strobe;
    assign VD            = r_vd;
    assign CD            = r_cd;
    assign VDE           = r_vde;
    assign locked        = r_locked;
    assign symbol_raw    = r_raw;

endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Bench for tmds_rx_decoder: directed tables and sequences plus a randomized
// bit stream compared every clock against a behavioural receiver model.
module tb_tmds_rx_decoder;

    localparam int LOCK = 8;
    localparam int ERR  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tin = 1'b0;
    logic       symbol_strobe;
    logic [7:0] VD;
    logic [1:0] CD;
    logic       VDE;
    logic       locked;
    logic [9:0] symbol_raw;

    tmds_rx_decoder #(.lock_tokens(LOCK), .err_limit(ERR)) dut (
        .clk_tmds      (clk),
        .reset         (rst),
        .tmds_in       (tin),
        .symbol_strobe (symbol_strobe),
        .VD            (VD),
        .CD            (CD),
        .VDE           (VDE),
        .locked        (locked),
        .symbol_raw    (symbol_raw)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int last_strobe = 0;
    int gap = 0;
    logic [7:0] cap_vd;
    logic [1:0] cap_cd;
    logic       cap_vde;

    logic [9:0] tok_tab [4];

    // Behavioural model state: window of the last ten wire bits, clocks since anchor.
    logic [9:0] m_win;
    int         m_ticks;
    bit         m_verify, m_synced;
    int         m_good, m_bad;
    logic       e_strobe, e_vde, e_lock;
    logic [7:0] e_vd;
    logic [1:0] e_cd;
    logic [9:0] e_raw;

    typedef struct {
        logic [7:0] d;
        bit         is_ctl;
        logic [1:0] c;
        logic [7:0] e_vd;
        logic [1:0] e_cd;
        bit         e_vde;
    } vec_t;
    vec_t tbl [9];

    function automatic int tok_idx(input logic [9:0] w);
        for (int k = 0; k < 4; k++) if (w == tok_tab[k]) return k;
        return -1;
    endfunction

    // Reference encoder (transition-minimising stage plus simple DC balance choice).
    function automatic logic [9:0] enc(input logic [7:0] d);
        logic [7:0] q;
        bit xn;
        int n1;
        n1 = $countones(d);
        xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        if ($countones(q) > 4) return {1'b1, ~xn, ~q};
        return {1'b0, ~xn, q};
    endfunction

    // Decode by searching for the byte whose forward chain reproduces the payload.
    function automatic logic [7:0] ref_decode(input logic [9:0] w);
        logic [7:0] x, q, d;
        x = w[9] ? ~w[7:0] : w[7:0];
        for (int v = 0; v < 256; v++) begin
            d = 8'(v);
            q[0] = d[0];
            for (int i = 1; i < 8; i++) q[i] = w[8] ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
            if (q == x) return d;
        end
        return 8'h00;
    endfunction

    task automatic model_reset();
        m_win = '0; m_ticks = 0; m_verify = 0; m_synced = 0; m_good = 0; m_bad = 0;
        e_strobe = 0; e_vde = 0; e_lock = 0; e_vd = '0; e_cd = '0; e_raw = '0;
    endtask

    task automatic model_step(input logic b);
        int  code;
        bit  bnd;
        code = tok_idx(m_win);
        bnd  = (m_ticks % 10 == 9);
        e_strobe = 1'b0;
        if (m_synced) begin
            if (bnd) begin
                e_strobe = 1'b1;
                e_raw    = m_win;
                if (code >= 0) begin
                    e_vde = 1'b0; e_cd = 2'(code); m_bad = 0;
                end else begin
                    e_vde = 1'b1; e_vd = ref_decode(m_win);
                end
            end else if (code >= 0) begin
                m_bad++;
                if (m_bad >= ERR) begin m_synced = 0; m_bad = 0; m_good = 0; end
            end
        end else if (m_verify) begin
            if (bnd) begin
                if (code >= 0) begin
                    m_good++;
                    if (m_good >= LOCK) begin m_verify = 0; m_synced = 1; m_bad = 0; end
                end else begin
                    m_verify = 0; m_good = 0;
                end
            end
        end else if (code >= 0) begin
            m_verify = 1; m_good = 1; m_ticks = 9;
        end
        e_lock  = m_synced;
        m_ticks = m_ticks + 1;
        m_win   = {b, m_win[9:1]};
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        tin = b;
        @(posedge clk);
        model_step(b);
        cyc++;
        #1;
        if (symbol_strobe === 1'b1) begin
            cap_vd = VD; cap_cd = CD; cap_vde = VDE;
            gap = cyc - last_strobe;
            last_strobe = cyc;
        end
        n_vec++;
        if ({symbol_strobe, VD, CD, VDE, locked, symbol_raw} !==
            {e_strobe, e_vd, e_cd, e_vde, e_lock, e_raw}) begin
            n_err++;
            $display("FAIL model cyc %0d: got stb=%b vd=%h cd=%b vde=%b lck=%b raw=%b expected stb=%b vd=%h cd=%b vde=%b lck=%b raw=%b",
                     cyc, symbol_strobe, VD, CD, VDE, locked, symbol_raw,
                     e_strobe, e_vd, e_cd, e_vde, e_lock, e_raw);
        end
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) send_bit(s[i]);
    endtask

    task automatic send_toks(input int n, input int code);
        for (int i = 0; i < n; i++) send_sym(tok_tab[code]);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        model_reset();
        #1 chk("async_reset_outputs", 32'({symbol_strobe, VD, CD, VDE, locked, symbol_raw}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tok_tab[0] = 10'b1101010100;
        tok_tab[1] = 10'b0010101011;
        tok_tab[2] = 10'b0101010100;
        tok_tab[3] = 10'b1010101011;

        tbl[0] = '{8'h00, 0, 2'b00, 8'h00, 2'b00, 1};
        tbl[1] = '{8'hFF, 0, 2'b00, 8'hFF, 2'b00, 1};
        tbl[2] = '{8'h80, 0, 2'b00, 8'h80, 2'b00, 1};
        tbl[3] = '{8'h5A, 0, 2'b00, 8'h5A, 2'b00, 1};
        tbl[4] = '{8'hA5, 0, 2'b00, 8'hA5, 2'b00, 1};
        tbl[5] = '{8'h00, 1, 2'b00, 8'hA5, 2'b00, 0};
        tbl[6] = '{8'h00, 1, 2'b01, 8'hA5, 2'b01, 0};
        tbl[7] = '{8'h00, 1, 2'b10, 8'hA5, 2'b10, 0};
        tbl[8] = '{8'h00, 1, 2'b11, 8'hA5, 2'b11, 0};

        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 chk("reset_outputs", 32'({symbol_strobe, VD, CD, VDE, locked, symbol_raw}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Acquisition after a random preamble.
        for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
        send_toks(8, 0);
        chk("lock_before_8th_seen", 32'(locked), 32'd0);
        send_toks(1, 0);
        chk("lock_after_8th", 32'(locked), 32'd1);
        send_toks(3, 0);
        chk("acq_cd", 32'(cap_cd), 32'd0);
        chk("acq_vde", 32'(cap_vde), 32'd0);
        chk("strobe_period", 32'(gap), 32'd10);

        // Data and control decode table; each entry is checked at the following strobe.
        for (int k = 0; k <= 9; k++) begin
            cap_vd = 'x; cap_cd = 'x; cap_vde = 'x;
            if (k < 9) send_sym(tbl[k].is_ctl ? tok_tab[tbl[k].c] : enc(tbl[k].d));
            else       send_sym(tok_tab[0]);
            if (k > 0) begin
                chk($sformatf("tbl%0d_vd", k-1), 32'(cap_vd), 32'(tbl[k-1].e_vd));
                chk($sformatf("tbl%0d_cd", k-1), 32'(cap_cd), 32'(tbl[k-1].e_cd));
                chk($sformatf("tbl%0d_vde", k-1), 32'(cap_vde), 32'(tbl[k-1].e_vde));
            end
        end

        // Asynchronous reset mid-symbol while locked.
        for (int i = 0; i < 4; i++) send_bit(tok_tab[0][i]);
        do_reset();

        // False start: two tokens then data at the boundary.
        send_toks(2, 0);
        send_sym(enc(8'h5A));
        send_toks(1, 0);
        chk("false_start_unlocked", 32'(locked), 32'd0);
        send_toks(7, 0);
        chk("false_start_not_yet", 32'(locked), 32'd0);
        send_toks(1, 0);
        chk("false_start_relock", 32'(locked), 32'd1);

        // Slip by one bit: off-phase tokens drop lock, then relock on the new phase.
        send_bit(1'b0);
        send_toks(4, 0);
        chk("slip_still_locked", 32'(locked), 32'd1);
        send_toks(1, 0);
        chk("slip_lost", 32'(locked), 32'd0);
        send_toks(7, 0);
        chk("slip_relock_pending", 32'(locked), 32'd0);
        send_toks(1, 0);
        chk("slip_relocked", 32'(locked), 32'd1);

        // Randomized stream against the model.
        for (int it = 0; it < 80; it++) begin
            int r;
            r = int'($urandom_range(0, 11));
            if (it == 40) do_reset();
            if (r <= 3)       send_sym(tok_tab[$urandom_range(0, 3)]);
            else if (r <= 7)  send_sym(enc(8'($urandom_range(0, 255))));
            else if (r == 8)  for (int i = 0, n = int'($urandom_range(1, 9)); i < n; i++) send_bit(1'($urandom_range(0, 1)));
            else if (r == 9)  send_toks(10, int'($urandom_range(0, 3)));
            else if (r == 10) for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
            else              send_toks(3, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
